// File: rtl/project_shadow_register_file.sv
// Double-buffered PWM configuration register file. Host writes go to a shadow bank,
// and each channel's active bank is reloaded atomically at its period end or on a forced update.
module project_shadow_register_file #(
    parameter int NUM_CHANNELS     = 3,
    parameter int REGS_PER_CHANNEL = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int ADDRESS_WIDTH    = 6
) (
    input  logic                                                i_clk,
    input  logic                                                i_reset,
    input  logic                                                i_write_en,
    input  logic                                                i_read_en,
    input  logic [ADDRESS_WIDTH-1:0]                            i_address,
    input  logic [DATA_WIDTH-1:0]                               i_data,
    output logic [DATA_WIDTH-1:0]                               o_data,
    output logic                                                o_read_valid,
    input  logic [NUM_CHANNELS-1:0]                             i_period_end,
    output logic [NUM_CHANNELS*REGS_PER_CHANNEL*DATA_WIDTH-1:0] o_active_regs,
    output logic [NUM_CHANNELS-1:0]                             o_update_pending,
    output logic                                                o_write_error
);

    localparam int NUM_REGS = NUM_CHANNELS * REGS_PER_CHANNEL;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_CTRL   = ADDRESS_WIDTH'(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STATUS = ADDRESS_WIDTH'(NUM_REGS + 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_FORCE  = ADDRESS_WIDTH'(NUM_REGS + 2);

    logic [DATA_WIDTH-1:0]   shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   shadow_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]   active_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   active_d [NUM_REGS];
    logic [1:0]              ctrl_q, ctrl_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    werr_q, werr_d;

    logic                    hit_chan;
    logic                    wr_chan_ok;
    logic                    wr_ctrl;
    logic                    wr_force;
    logic [NUM_CHANNELS-1:0] xfer;
    logic [DATA_WIDTH-1:0]   rd_val;

    always_comb begin
        hit_chan   = (i_address < ADDR_CTRL);
        wr_chan_ok = i_write_en && hit_chan && !ctrl_q[0];
        wr_ctrl    = i_write_en && (i_address == ADDR_CTRL);
        wr_force   = i_write_en && (i_address == ADDR_FORCE);
        werr_d     = i_write_en && !(wr_chan_ok || wr_ctrl || wr_force);

        // Period end only reloads a channel with fresh shadow data; a forced update reloads unconditionally.
        xfer = (i_period_end & pending_q)
             | (wr_force ? i_data[NUM_CHANNELS-1:0] : '0);

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ctrl_d    = wr_ctrl ? i_data[1:0] : ctrl_q;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (xfer[c]) begin
                pending_d[c] = 1'b0;
                for (int r = 0; r < REGS_PER_CHANNEL; r++) begin
                    active_d[c*REGS_PER_CHANNEL + r] = shadow_q[c*REGS_PER_CHANNEL + r];
                end
            end
        end

        // A write after the transfer so a same-cycle write leaves the channel pending.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_chan_ok && (i_address == ADDRESS_WIDTH'(i))) begin
                shadow_d[i]                     = i_data;
                pending_d[i / REGS_PER_CHANNEL] = 1'b1;
            end
        end

        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_address == ADDRESS_WIDTH'(i)) begin
                rd_val = ctrl_q[1] ? active_q[i] : shadow_q[i];
            end
        end
        if (i_address == ADDR_CTRL) begin
            rd_val = DATA_WIDTH'(ctrl_q);
        end
        if (i_address == ADDR_STATUS) begin
            rd_val = DATA_WIDTH'(pending_q);
        end

        rvalid_d = i_read_en;
        rdata_d  = i_read_en ? rd_val : rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            ctrl_q    <= '0;
            pending_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            werr_q    <= werr_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_active_regs[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

    assign o_data           = rdata_q;
    assign o_read_valid     = rvalid_q;
    assign o_update_pending = pending_q;
    assign o_write_error    = werr_q;

endmodule

// File: doc/project_shadow_register_file.md
Name: project_shadow_register_file

Overview:
Parametrised, double-buffered configuration register file for the PWM peripheral, covering N channels of R registers each. Host writes land in a shadow bank. Each channel's shadow bank is copied to its active bank only on that channel's period-end pulse, or on a host force-update, so PWM timers never see a half-written configuration. Adds a global lock, pending-status tracking, registered read-back of either bank, and error flagging. Sits between the host byte interface and the per-channel period counter/compare blocks.

Parameters:
NUM_CHANNELS, 3, number of PWM channels; range 1..DATA_WIDTH.
REGS_PER_CHANNEL, 16, registers per channel.
DATA_WIDTH, 8, register width in bits.
ADDRESS_WIDTH, 6, host address width; NUM_CHANNELS*REGS_PER_CHANNEL+3 <= 2**ADDRESS_WIDTH.

Ports:
i_clk  in  1  clock, all state on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_write_en  in  1  host write strobe, one write per cycle.
i_read_en  in  1  host read strobe.
i_address  in  ADDRESS_WIDTH  host address.
i_data  in  DATA_WIDTH  host write data.
o_data  out  DATA_WIDTH  registered read data.
o_read_valid  out  1  high the cycle after an accepted read.
i_period_end  in  NUM_CHANNELS  per-channel period-boundary pulse from the counters.
o_active_regs  out  NUM_CHANNELS*REGS_PER_CHANNEL*DATA_WIDTH  flattened active bank; channel c, register r at bits [(c*REGS_PER_CHANNEL+r)*DATA_WIDTH +: DATA_WIDTH].
o_update_pending  out  NUM_CHANNELS  shadow differs from active (written since the last transfer).
o_write_error  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Address map. Let CH_END = NUM_CHANNELS*REGS_PER_CHANNEL.
  - Address c*REGS_PER_CHANNEL+r selects channel c, register r.
  - CH_END = GLOBAL_CTRL (R/W): bit0 LOCK, bit1 READ_ACTIVE; other bits read 0.
  - CH_END+1 = STATUS (RO): pending bits in [NUM_CHANNELS-1:0].
  - CH_END+2 = FORCE_UPDATE (WO): bitmask of channels to transfer now; reads 0.
  - Addresses above CH_END+2 are unmapped.
- Reset (sync, i_reset high at an edge): shadow, active, GLOBAL_CTRL, o_data, o_read_valid, o_update_pending and o_write_error all 0. Reset overrides every other event in the same cycle, including an in-progress read.
- Write to a channel register:
  - LOCK=0: shadow[c][r] <= i_data, and pending[c] <= 1.
  - LOCK=1: write ignored and o_write_error pulses.
- Write to GLOBAL_CTRL: always accepted, including while locked.
- Write to STATUS or to an unmapped address: ignored; o_write_error pulses.
- Transfer: if i_period_end[c] && pending[c], or a FORCE_UPDATE write has bit c set (force does not require pending):
  - active[c][*] <= shadow[c][*], copying all registers atomically in one edge.
  - pending[c] <= 0.
  - New values appear on o_active_regs one cycle after the triggering edge input.
- i_period_end[c] with pending[c]=0: no change.
- Simultaneous channel write and transfer on the same channel:
  - The transfer copies the pre-write shadow.
  - The write still lands in shadow.
  - pending[c] ends at 1.
- Read: i_read_en sampled at the edge; o_data and o_read_valid are driven the following cycle.
  - Channel register: returns shadow, or active if READ_ACTIVE=1.
  - Unmapped or WO address: returns 0.
  - o_read_valid is 0 when no read was issued; o_data holds its last value.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- o_write_error: high exactly one cycle per rejected write; never asserts on reads.
- No combinational path from host inputs to any output.

Test Plan:
1. Reset, write 0x5A to ch1 reg3 (addr 0x13) → STATUS reads 0x02; o_active_regs ch1 reg3 still 0x00; pulse i_period_end=3'b010 → next cycle active = 0x5A, pending 0.
2. Write 0x01 to GLOBAL_CTRL (0x30) then 0xFF to addr 0x05 → o_write_error pulses 1 cycle, shadow unchanged, STATUS 0x00; write 0x00 to 0x30 and retry → accepted, pending bit0 set.
3. Write 0x11 to ch2 reg0 (0x20) and 0x22 to ch0 reg0, then write 0x05 to FORCE_UPDATE (0x32) with no period_end → both active values update in the same cycle; STATUS 0x00.
4. Ch0 reg2 shadow=0xA0 and pending; same cycle: write 0xB0 to 0x02 and i_period_end[0]=1 → active=0xA0, shadow=0xB0, pending[0]=1.
5. Read 0x02 with READ_ACTIVE=0 then =1 → o_read_valid one cycle after each strobe, returns 0xB0 then 0xA0. Read 0x3F → 0x00. Write to 0x3F → o_write_error.
6. Assert i_reset for one cycle while pending=3'b111 and a read is issued → next cycle all outputs 0, o_read_valid 0.
